// File: rtl/ks_pkg.sv
// Shared constants and helpers for the pipelined Kogge-Stone carry network.
package ks_pkg;

  localparam int unsigned KS_WIDTH = 16;

  function automatic int unsigned ks_levels(input int unsigned width);
    int unsigned l;
    l = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < width) l = i + 1;
    end
    return l;
  endfunction

  // One PG register stage plus one register per prefix level.
  function automatic int unsigned ks_stages(input int unsigned width);
    return ks_levels(width) + 1;
  endfunction

  localparam int unsigned KS_LEVELS = ks_levels(KS_WIDTH);
  localparam int unsigned KS_STAGES = ks_stages(KS_WIDTH);

endpackage

// File: rtl/ks_black_cell.sv
// Kogge-Stone prefix operator: combines (G,P) of a span with the span below it.
module ks_black_cell (
  input  logic gi,
  input  logic pi,
  input  logic gj,
  input  logic pj,
  output logic go,
  output logic po
);

  assign go = gi | (pi & gj);
  assign po = pi & pj;

endmodule

// File: rtl/ks_carry_pipe.sv
// Pipelined Kogge-Stone carry network with per-stage valid/ready flow control.
module ks_carry_pipe
  import ks_pkg::*;
#(
  parameter int unsigned WIDTH = KS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_c,
  output logic             out_cout
);

  localparam int unsigned LEVELS  = ks_levels(WIDTH);
  localparam int unsigned NSTAGES = ks_stages(WIDTH);

  logic [NSTAGES-1:0] v_q, v_d;
  logic [NSTAGES-1:0] ready;
  logic [NSTAGES-1:0] ci_q, ci_d;
  logic [WIDTH-1:0]   g_q  [NSTAGES];
  logic [WIDTH-1:0]   g_d  [NSTAGES];
  logic [WIDTH-1:0]   pp_q [NSTAGES];
  logic [WIDTH-1:0]   pp_d [NSTAGES];
  logic [WIDTH-1:0]   p_q  [NSTAGES];
  logic [WIDTH-1:0]   p_d  [NSTAGES];
  logic [WIDTH-1:0]   lvl_g [1:LEVELS];
  logic [WIDTH-1:0]   lvl_p [1:LEVELS];
  logic [WIDTH-1:0]   pg_g, pg_p;
  logic               ks_unused;

  always_comb begin
    pg_p    = a ^ b;
    pg_g    = a & b;
    pg_g[0] = (a[0] & b[0]) | (pg_p[0] & cin);
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int D = 2 ** (l - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_cell
        ks_black_cell u_cell (
          .gi (g_q[l-1][i]),
          .pi (pp_q[l-1][i]),
          .gj (g_q[l-1][i-D]),
          .pj (pp_q[l-1][i-D]),
          .go (lvl_g[l][i]),
          .po (lvl_p[l][i])
        );
      end else begin : g_pass
        assign lvl_g[l][i] = g_q[l-1][i];
        assign lvl_p[l][i] = pp_q[l-1][i];
      end
    end
  end

  // Stage k may load if it is empty or its successor is loading this cycle.
  always_comb begin : ready_chain
    logic r;
    r     = out_ready;
    ready = '0;
    for (int unsigned k = 0; k < NSTAGES; k++) begin
      ready[NSTAGES-1-k] = !v_q[NSTAGES-1-k] || r;
      r                  = ready[NSTAGES-1-k];
    end
  end

  always_comb begin
    v_d  = v_q;
    ci_d = ci_q;
    g_d  = g_q;
    pp_d = pp_q;
    p_d  = p_q;
    if (ready[0]) v_d[0] = in_valid;
    if (ready[0] && in_valid) begin
      g_d[0]  = pg_g;
      pp_d[0] = pg_p;
      p_d[0]  = pg_p;
      ci_d[0] = cin;
    end
    for (int unsigned k = 1; k < NSTAGES; k++) begin
      if (ready[k]) v_d[k] = v_q[k-1];
      if (ready[k] && v_q[k-1]) begin
        g_d[k]  = lvl_g[k];
        pp_d[k] = lvl_p[k];
        p_d[k]  = p_q[k-1];
        ci_d[k] = ci_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      ci_q <= '0;
      for (int unsigned k = 0; k < NSTAGES; k++) begin
        g_q[k]  <= '0;
        pp_q[k] <= '0;
        p_q[k]  <= '0;
      end
    end else begin
      v_q  <= v_d;
      ci_q <= ci_d;
      g_q  <= g_d;
      pp_q <= pp_d;
      p_q  <= p_d;
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = v_q[NSTAGES-1];
  assign out_p     = p_q[NSTAGES-1];
  assign out_c     = {g_q[NSTAGES-1][WIDTH-2:0], ci_q[NSTAGES-1]};
  assign out_cout  = g_q[NSTAGES-1][WIDTH-1];
  assign ks_unused = ^pp_q[NSTAGES-1];

endmodule

// File: tb/tb_ks_carry_pipe.sv
// Self-checking bench for ks_carry_pipe against an arithmetic reference of a+b+cin.
module tb_ks_carry_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_p, out_c;
  logic         out_cout;

  always #5 clk = ~clk;

  ks_carry_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_c     (out_c),
    .out_cout  (out_cout)
  );

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] c;
    logic         cout;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   chk_lat = 1'b0;

  // Carries follow from the true sum: c = sum ^ p, cout = bit W of the sum.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input int at);
    exp_t        r;
    logic [W:0]  s;
    s      = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    r.p    = av ^ bv;
    r.c    = s[W-1:0] ^ (av ^ bv);
    r.cout = s[W];
    r.acc  = at;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cycle(output bit acc);
    exp_t e;
    bit   emit;
    #1;
    acc = 1'b0;
    if (!rst) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 5) || out_ready});
      if (q.size() == 0) begin
        chk("spurious_valid", {31'b0, out_valid}, 32'd0);
      end else if (out_valid) begin
        e = q[0];
        chk("out_p", {16'b0, out_p}, {16'b0, e.p});
        chk("out_c", {16'b0, out_c}, {16'b0, e.c});
        chk("out_cout", {31'b0, out_cout}, {31'b0, e.cout});
      end
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready && (q.size() > 0);
      if (emit && chk_lat) chk("latency", cyc - q[0].acc, 32'd5);
      if (emit) void'(q.pop_front());
      if (acc) q.push_back(model(a, b, cin, cyc));
    end
    @(posedge clk);
    cyc++;
    if (rst) q.delete();
    #1;
  endtask

  task automatic drain();
    bit ac;
    for (int i = 0; i < 40 && q.size() > 0; i++) cycle(ac);
    chk("drain_pending", q.size(), 32'd0);
  endtask

  task automatic send_one(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    bit ac;
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    cycle(ac);
    chk("accept", {31'b0, ac}, 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           ac;
    int           n;
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vc [8];

    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'b1;
    cycle(ac);
    cycle(ac);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_p", {16'b0, out_p}, 32'd0);
    chk("rst_out_c", {16'b0, out_c}, 32'd0);
    chk("rst_out_cout", {31'b0, out_cout}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    out_ready = 1'b1; chk_lat = 1'b1;
    send_one(16'h1234, 16'h4321, 1'b0); drain();
    send_one(16'hFFFF, 16'h0001, 1'b0); drain();
    send_one(16'h0000, 16'h0000, 1'b1); drain();

    for (int i = 0; i < 16; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      cycle(ac);
      chk("b2b_accept", {31'b0, ac}, 32'd1);
    end
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 8; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom); vc[i] = 1'($urandom);
    end
    chk_lat = 1'b0; out_ready = 1'b0; n = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (n < 8);
      if (n < 8) begin a = va[n]; b = vb[n]; cin = vc[n]; end
      cycle(ac);
      if (ac) n++;
    end
    #1;
    chk("stall_accepts", n, 32'd5);
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && n < 8; i++) begin
      in_valid = 1'b1;
      a = va[n]; b = vb[n]; cin = vc[n];
      cycle(ac);
      if (ac) n++;
    end
    in_valid = 1'b0;
    chk("stall_all_sent", n, 32'd8);
    drain();

    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      cycle(ac);
    end
    rst = 1'b1; in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    cycle(ac);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_out_p", {16'b0, out_p}, 32'd0);
    chk("mid_rst_out_c", {16'b0, out_c}, 32'd0);
    chk("mid_rst_out_cout", {31'b0, out_cout}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) cycle(ac);
    send_one(W'($urandom), W'($urandom), 1'($urandom));
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
